// File: rtl/cache_defs.sv
// Shared widths and FSM encoding for the direct-mapped MEM-stage cache.
// CACHE_STATS_EN (top-level option) adds hit/miss counters.
package cache_defs;

  localparam int TAG_W      = 20;
  localparam int INDEX_W    = 8;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: combinational read port, synchronous write port.
// Valid bits are flops cleared by reset; tag and data are plain storage.
module cache_line_store
  import cache_defs::*;
#(
  parameter int TAG   = TAG_W,
  parameter int INDEX = INDEX_W,
  parameter int WORDS = LINE_WORDS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INDEX-1:0]           ridx,
  input  logic [$clog2(WORDS)-1:0]   rword,
  output logic                       rvalid,
  output logic [TAG-1:0]             rtag,
  output logic [31:0]                rdata,
  input  logic                       inv,
  input  logic [INDEX-1:0]           inv_idx,
  input  logic                       we,
  input  logic [INDEX-1:0]           widx,
  input  logic [$clog2(WORDS)-1:0]   wword,
  input  logic [31:0]                wdata,
  input  logic                       tag_we,
  input  logic [TAG-1:0]             wtag
);

  localparam int LINES = 2 ** INDEX;

  logic [LINES-1:0] valid;
  logic [TAG-1:0]   tags [LINES];
  logic [31:0]      data [LINES][WORDS];

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx][rword];

  // A line is invalidated when its refill starts so a torn fill never hits.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (inv)
        valid[inv_idx] <= 1'b0;
      if (tag_we)
        valid[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we)
      tags[widx] <= wtag;
    if (we)
      data[widx][wword] <= wdata;
  end

endmodule

// File: rtl/equals_cache.sv
// 32-bit tag compare cell used for hit detection.
// Pure combinational equality.
module equals_cache (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq
);

  assign eq = (a == b);

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped write-through no-write-allocate MEM-stage cache controller.
// Define CACHE_STATS_EN to add hit_cnt/miss_cnt outputs.
module cache_ctrl_dm
  import cache_defs::*;
#(
  parameter int TAG   = TAG_W,
  parameter int INDEX = INDEX_W,
  parameter int WORDS = LINE_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF = $clog2(WORDS);

  state_t           state;
  logic [OFF-1:0]   cnt;
  logic             st_hit;

  logic [TAG-1:0]   a_tag;
  logic [INDEX-1:0] a_idx;
  logic [OFF-1:0]   a_word;
  logic [TAG-1:0]   m_tag;
  logic [INDEX-1:0] m_idx;
  logic [OFF-1:0]   m_word;

  assign a_tag  = cpu_addr[31 -: TAG];
  assign a_idx  = cpu_addr[2+OFF +: INDEX];
  assign a_word = cpu_addr[2 +: OFF];
  assign m_tag  = mem_addr[31 -: TAG];
  assign m_idx  = mem_addr[2+OFF +: INDEX];
  assign m_word = mem_addr[2 +: OFF];

  logic             rvalid;
  logic [TAG-1:0]   rtag;
  logic [31:0]      rword;
  logic             tag_eq;
  logic             hit;
  logic             go_fill;
  logic             ack_fill;
  logic             last;
  logic             wr_en;

  equals_cache u_eq (
    .a  ({{(32-TAG){1'b0}}, rtag}),
    .b  ({{(32-TAG){1'b0}}, a_tag}),
    .eq (tag_eq)
  );

  assign hit      = rvalid & tag_eq;
  assign go_fill  = (state == IDLE) & cpu_req & ~cpu_we & ~hit;
  assign ack_fill = (state == FILL) & mem_ack;
  assign last     = (cnt == OFF'(WORDS - 1));
  assign wr_en    = ack_fill
                  | ((state == WRITE) & mem_ack & st_hit);

  // Fill and store writes take their line address from mem_addr.
  cache_line_store #(
    .TAG   (TAG),
    .INDEX (INDEX),
    .WORDS (WORDS)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .ridx    (a_idx),
    .rword   (a_word),
    .rvalid  (rvalid),
    .rtag    (rtag),
    .rdata   (rword),
    .inv     (go_fill),
    .inv_idx (a_idx),
    .we      (wr_en),
    .widx    (m_idx),
    .wword   (m_word),
    .wdata   ((state == FILL) ? mem_rdata : mem_wdata),
    .tag_we  (ack_fill & last),
    .wtag    (m_tag)
  );

  assign cpu_rdata = hit ? rword : 32'h0;

  always_comb begin
    cpu_stall = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE:    cpu_stall = cpu_req & (cpu_we | ~hit);
        FILL:    cpu_stall = 1'b1;
        WRITE:   cpu_stall = ~mem_ack;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      st_hit    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            state     <= WRITE;
            st_hit    <= hit;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_addr & ~32'h3;
            mem_wdata <= cpu_wdata;
          end else if (go_fill) begin
            state    <= FILL;
            cnt      <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {a_tag, a_idx, {OFF{1'b0}}, 2'b00};
          end
        end
        FILL: begin
          if (mem_ack) begin
            cnt              <= cnt + OFF'(1);
            mem_addr[2+:OFF] <= cnt + OFF'(1);
            if (last) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == IDLE) && cpu_req && !cpu_we && hit)
        hit_cnt <= hit_cnt + 32'd1;
      if (go_fill)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Randomized bench for cache_ctrl_dm against a memory/residency model.
// Build with CACHE_STATS_EN to also check the hit/miss counters.
module tb_cache_ctrl_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  cache_ctrl_dm dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } txn_t;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          dly    = 0;
  txn_t        trq[$];
  logic [31:0] mem [int unsigned];
  bit          res_v   [256];
  logic [19:0] res_tag [256];
  int          exp_hits, exp_miss;
  logic [31:0] last_rdata;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  always @(posedge clk) cyc++;

  // Memory slave: random latency, one-cycle ack pulse.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mem_ack = 1'b0;
      dly = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (dly == 0) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem_rd(mem_addr);
        trq.push_back('{mem_we, mem_addr, mem_wdata, cyc});
        mem_ack = 1'b1;
        dly = $urandom_range(0, 2);
      end else begin
        dly--;
      end
    end
  end

  // Every retired load must return the current memory contents.
  logic        p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
  logic [31:0] p_addr, p_wd;
  always @(negedge clk) begin
    if (!reset && cpu_req && !cpu_we && !cpu_stall)
      chk(cpu_rdata == mem_rd(cpu_addr & ~32'h3), "rdata",
          cpu_rdata, mem_rd(cpu_addr & ~32'h3));
    if (!reset && !p_rst && p_req && !p_ack)
      chk(mem_req && mem_addr == p_addr && mem_wdata == p_wd,
          "mem_hold", mem_addr, p_addr);
    p_req  = mem_req;
    p_ack  = mem_ack;
    p_rst  = reset;
    p_addr = mem_addr;
    p_wd   = mem_wdata;
  end

  task automatic clear_model();
    for (int i = 0; i < 256; i++) res_v[i] = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    trq.delete();
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
    @(negedge clk);
    chk(!cpu_stall, "rst_stall", 32'(cpu_stall), 0);
    chk(!mem_req, "rst_req", 32'(mem_req), 0);
    chk(!mem_we, "rst_we", 32'(mem_we), 0);
    chk(mem_addr == 0, "rst_addr", mem_addr, 0);
    chk(mem_wdata == 0, "rst_wdata", mem_wdata, 0);
    chk(cpu_rdata == 0, "rst_rdata", cpu_rdata, 0);
`ifdef CACHE_STATS_EN
    chk(hit_cnt == 0, "rst_hits", hit_cnt, 0);
    chk(miss_cnt == 0, "rst_miss", miss_cnt, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  // Caller is just past a rising edge; returns just past a rising edge.
  task automatic do_op(input bit we, input logic [31:0] addr,
                       input logic [31:0] wd);
    int          ix;
    bit          exp_hit, done;
    logic [31:0] base;
    ix = int'(addr[11:4]);
    exp_hit = res_v[ix] && res_tag[ix] == addr[31:12];
    base = {addr[31:4], 4'h0};
    done = 1'b0;
    trq.delete();
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0)
        chk(cpu_stall == (we || !exp_hit), "first_stall",
            32'(cpu_stall), 32'(we || !exp_hit));
      if (!cpu_stall) begin
        done = 1'b1;
        last_rdata = cpu_rdata;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(done, "op_timeout", 32'(done), 1);
    if (we) begin
      chk(trq.size() == 1, "wr_count", trq.size(), 1);
      if (trq.size() == 1) begin
        chk(trq[0].we, "wr_we", 32'(trq[0].we), 1);
        chk(trq[0].a == (addr & ~32'h3), "wr_addr", trq[0].a,
            addr & ~32'h3);
        chk(trq[0].d == wd, "wr_data", trq[0].d, wd);
      end
    end else if (exp_hit) begin
      chk(trq.size() == 0, "hit_nomem", trq.size(), 0);
    end else begin
      chk(trq.size() == 4, "fill_count", trq.size(), 4);
      if (trq.size() == 4) begin
        for (int i = 0; i < 4; i++)
          chk(!trq[i].we && trq[i].a == base + 32'(4 * i), "fill_addr",
              trq[i].a, base + 32'(4 * i));
        chk(cyc - trq[3].cyc == 1, "fill_lat", 32'(cyc - trq[3].cyc), 1);
      end
    end
    if (!we) begin
      exp_hits++;
      if (!exp_hit) begin
        exp_miss++;
        res_v[ix] = 1'b1;
        res_tag[ix] = addr[31:12];
      end
    end
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    bit          got2;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      mem[32'h40 + 32'(4 * i)] = 32'ha000_0040 + 32'(4 * i);
    do_reset();

    do_op(1'b0, 32'h0000_0040, '0);
    chk(last_rdata == 32'ha000_0040, "t1_rdata", last_rdata, 32'ha000_0040);
    do_op(1'b0, 32'h0000_0048, '0);
    chk(last_rdata == 32'ha000_0048, "t2_rdata", last_rdata, 32'ha000_0048);
    do_op(1'b0, 32'h0010_0040, '0);
    do_op(1'b0, 32'h0000_0040, '0);
    chk(exp_miss == 3, "t3_misses", exp_miss, 3);
    do_op(1'b1, 32'h0000_0044, 32'hdead_beef);
    do_op(1'b0, 32'h0000_0044, '0);
    chk(last_rdata == 32'hdead_beef, "t4_rdata", last_rdata, 32'hdead_beef);
    do_op(1'b1, 32'h2000_0000, 32'h1234_5678);
    do_op(1'b0, 32'h2000_0000, '0);
    chk(last_rdata == 32'h1234_5678, "t5_rdata", last_rdata, 32'h1234_5678);

    // Reset after two fill acks abandons the line.
    a = 32'h0003_0050;
    trq.delete();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = a;
    got2 = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (trq.size() >= 2) begin
        got2 = 1'b1;
        break;
      end
    end
    chk(got2, "t6_two_acks", 32'(got2), 1);
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk(!mem_req, "t6_req", 32'(mem_req), 0);
    chk(!cpu_stall, "t6_stall", 32'(cpu_stall), 0);
`ifdef CACHE_STATS_EN
    chk(hit_cnt == 0, "t6_hits", hit_cnt, 0);
    chk(miss_cnt == 0, "t6_miss", miss_cnt, 0);
`endif
    reset = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    do_op(1'b0, a, '0);

    for (int k = 0; k < 250; k++) begin
      a = {12'h0, 8'($urandom_range(0, 2)), 8'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (k % 3 == 0) a[31:28] = 4'h2;
      do_op($urandom_range(0, 9) < 4, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

`ifdef CACHE_STATS_EN
    chk(hit_cnt == 32'(exp_hits), "stat_hits", hit_cnt, 32'(exp_hits));
    chk(miss_cnt == 32'(exp_miss), "stat_miss", miss_cnt, 32'(exp_miss));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
